// File: rtl/window_average.sv
// Sliding-window mean over the last 2**DEPTH_LOG2 unsigned samples.
// The running sum is updated incrementally, so each strobe costs one add and one subtract.
module window_average #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 3,
  parameter int ROUND      = 0
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              addValue,
  input  logic [DATA_W-1:0] inputData,
  output logic              averageReady,
  output logic [DATA_W-1:0] outputData,
  output logic              windowFull
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int CNT_W     = DEPTH_LOG2 + 1;
  localparam int SUM_W     = DATA_W + DEPTH_LOG2 + ((ROUND != 0) ? 1 : 0);
  localparam int ROUND_INC = (ROUND != 0) ? (1 << (DEPTH_LOG2 - 1)) : 0;

  localparam logic [CNT_W-1:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     sampleMem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [CNT_W-1:0]      count;
  logic [SUM_W-1:0]      sum;

  logic                  accept;
  logic [DATA_W-1:0]     oldest;
  logic [SUM_W-1:0]      nextSum;
  logic [CNT_W-1:0]      nextCount;
  logic [SUM_W-1:0]      roundedSum;

  assign accept     = addValue && !clear;
  assign windowFull = (count == FULL_COUNT);

  // Until the window is full the slot under wrPtr holds stale data and must not be subtracted.
  assign oldest     = windowFull ? sampleMem[wrPtr] : '0;
  assign nextSum    = sum + SUM_W'(inputData) - SUM_W'(oldest);
  assign nextCount  = windowFull ? count : count + CNT_W'(1);
  assign roundedSum = nextSum + SUM_W'(ROUND_INC);

  // NOTE: sample storage has no reset on purpose; count gating hides stale entries,
  // and leaving it unreset lets synthesis map it onto plain RAM/register arrays.
  always_ff @(posedge clk) begin
    if (accept) begin
      sampleMem[wrPtr] <= inputData;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrPtr        <= '0;
      count        <= '0;
      sum          <= '0;
      outputData   <= '0;
      averageReady <= 1'b0;
    end else if (clear) begin
      wrPtr        <= '0;
      count        <= '0;
      sum          <= '0;
      outputData   <= '0;
      averageReady <= 1'b0;
    end else if (addValue) begin
      wrPtr <= wrPtr + DEPTH_LOG2'(1);
      count <= nextCount;
      sum   <= nextSum;
      if (nextCount == FULL_COUNT) begin
        outputData   <= DATA_W'(roundedSum >> DEPTH_LOG2);
        averageReady <= 1'b1;
      end else begin
        averageReady <= 1'b0;
      end
    end else begin
      averageReady <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_average.sv
// Bench for window_average: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_window_average;

  logic        tb_clk;
  logic        n_rst;
  logic        clear;
  logic        addValue;
  logic [31:0] inputData;

  logic        mainReady, rndReady, smlReady;
  logic [31:0] mainOut, rndOut;
  logic [7:0]  smlOut;
  logic        mainFull, rndFull, smlFull;

  int nVectors = 0;
  int nMiscompares = 0;

  window_average #(.DATA_W(32), .DEPTH_LOG2(3), .ROUND(0)) u_main (
    .clk(tb_clk), .n_rst(n_rst), .clear(clear), .addValue(addValue),
    .inputData(inputData), .averageReady(mainReady), .outputData(mainOut),
    .windowFull(mainFull)
  );

  window_average #(.DATA_W(32), .DEPTH_LOG2(3), .ROUND(1)) u_rnd (
    .clk(tb_clk), .n_rst(n_rst), .clear(clear), .addValue(addValue),
    .inputData(inputData), .averageReady(rndReady), .outputData(rndOut),
    .windowFull(rndFull)
  );

  window_average #(.DATA_W(8), .DEPTH_LOG2(1), .ROUND(0)) u_sml (
    .clk(tb_clk), .n_rst(n_rst), .clear(clear), .addValue(addValue),
    .inputData(inputData[7:0]), .averageReady(smlReady), .outputData(smlOut),
    .windowFull(smlFull)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic        clr;
    logic        add;
    logic [31:0] data;
    logic        expReady;
    logic [31:0] expOut;
    logic        expFull;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, clock once, and settle just past the edge.
  task automatic step(input logic clr, input logic add, input logic [31:0] data);
    clear     = clr;
    addValue  = add;
    inputData = data;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic addVec(input string name, input logic clr, input logic add, input logic [31:0] data,
                        input logic expReady, input logic [31:0] expOut, input logic expFull);
    vec_t v;
    v.name = name; v.clr = clr; v.add = add; v.data = data;
    v.expReady = expReady; v.expOut = expOut; v.expFull = expFull;
    vecs.push_back(v);
  endtask

  // Reference model: the window is literally the queue of the most recent samples.
  logic [31:0] q32[$];
  logic [7:0]  q8[$];
  logic        mReady, sReady;
  logic [31:0] mOut, mRnd;
  logic [7:0]  sOut;

  task automatic modelStep(input logic clr, input logic add, input logic [31:0] data);
    longint unsigned s;
    if (clr) begin
      q32.delete(); q8.delete();
      mReady = 1'b0; sReady = 1'b0;
      mOut = '0; mRnd = '0; sOut = '0;
    end else if (add) begin
      q32.push_back(data);
      if (q32.size() > 8) void'(q32.pop_front());
      q8.push_back(data[7:0]);
      if (q8.size() > 2) void'(q8.pop_front());
      mReady = (q32.size() == 8);
      if (mReady) begin
        s = 0;
        foreach (q32[k]) s += longint'(q32[k]);
        mOut = 32'(s / 8);
        mRnd = 32'((s + 4) / 8);
      end
      sReady = (q8.size() == 2);
      if (sReady) begin
        s = 0;
        foreach (q8[k]) s += longint'(q8[k]);
        sOut = 8'(s / 2);
      end
    end else begin
      mReady = 1'b0;
      sReady = 1'b0;
    end
  endtask

  initial begin
    longint unsigned expSum;
    logic [31:0] rdata;
    logic rclr, radd;

    clear = 1'b0; addValue = 1'b0; inputData = '0;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    check("reset_ready", 64'(mainReady), 64'(0));
    check("reset_out",   64'(mainOut),   64'(0));
    check("reset_full",  64'(mainFull),  64'(0));
    #1 n_rst = 1'b1;

    // Fill with seven 1s, then the filling strobe.
    for (int i = 0; i < 7; i++) addVec("fill", 0, 1, 32'd1, 0, 32'd0, 0);
    addVec("fill_8th", 0, 1, 32'd1, 1, 32'd1, 1);

    // Slide 54321 in, one strobe every 11 cycles.
    for (int i = 0; i < 8; i++) begin
      expSum = longint'(7 - i) + longint'(i + 1) * 54321;
      addVec("slide_pulse", 0, 1, 32'd54321, 1, 32'(expSum / 8), 1);
      for (int j = 0; j < 10; j++) addVec("slide_idle", 0, 0, 32'd0, 0, 32'(expSum / 8), 1);
    end

    // Clear wins over a simultaneous strobe, then back-to-back all-ones and zeros.
    addVec("clear_with_add", 1, 1, 32'd5, 0, 32'd0, 0);
    for (int i = 0; i < 7; i++) addVec("ones_fill", 0, 1, 32'hFFFF_FFFF, 0, 32'd0, 0);
    addVec("ones_8th", 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 8; i++) begin
      expSum = longint'(7 - i) * 64'hFFFF_FFFF;
      addVec("zeros_slide", 0, 1, 32'd0, 1, 32'(expSum / 8), 1);
    end
    addVec("zeros_idle", 0, 0, 32'd0, 0, 32'd0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].add, vecs[i].data);
      check({vecs[i].name, "_ready"}, 64'(mainReady), 64'(vecs[i].expReady));
      check({vecs[i].name, "_out"},   64'(mainOut),   64'(vecs[i].expOut));
      check({vecs[i].name, "_full"},  64'(mainFull),  64'(vecs[i].expFull));
    end

    // Rounding: 4 followed by seven zeros.
    step(1, 0, 0);
    step(0, 1, 32'd4);
    for (int i = 0; i < 7; i++) step(0, 1, 32'd0);
    check("round0_ready", 64'(mainReady), 64'(1));
    check("round0_out",   64'(mainOut),   64'(0));
    check("round1_ready", 64'(rndReady),  64'(1));
    check("round1_out",   64'(rndOut),    64'(1));

    // Clear after five strobes: a full eight fresh strobes are needed afterwards.
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'd7);
    step(1, 1, 32'd7);
    check("clr_mid_ready", 64'(mainReady), 64'(0));
    check("clr_mid_full",  64'(mainFull),  64'(0));
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 32'd3);
      check("clr_refill_ready", 64'(mainReady), 64'(0));
    end
    step(0, 1, 32'd3);
    check("clr_refill_pulse", 64'(mainReady), 64'(1));
    check("clr_refill_out",   64'(mainOut),   64'(3));

    // Asynchronous reset between edges, right after a pulse.
    step(1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'd9);
    check("pre_rst_ready", 64'(mainReady), 64'(1));
    check("pre_rst_out",   64'(mainOut),   64'(9));
    #1 n_rst = 1'b0;
    #1;
    check("async_rst_ready", 64'(mainReady), 64'(0));
    check("async_rst_out",   64'(mainOut),   64'(0));
    check("async_rst_full",  64'(mainFull),  64'(0));
    n_rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 32'd2);
      check("post_rst_ready", 64'(mainReady), 64'(0));
    end
    step(0, 1, 32'd2);
    check("post_rst_pulse", 64'(mainReady), 64'(1));
    check("post_rst_out",   64'(mainOut),   64'(2));

    // Two-entry, 8-bit instance: the second strobe fills the window.
    step(1, 0, 0);
    step(0, 1, 32'd1);
    check("sml_first_ready", 64'(smlReady), 64'(0));
    check("sml_first_full",  64'(smlFull),  64'(0));
    step(0, 1, 32'd1);
    check("sml_second_ready", 64'(smlReady), 64'(1));
    check("sml_second_out",   64'(smlOut),   64'(1));
    check("sml_second_full",  64'(smlFull),  64'(1));

    // Randomized traffic against the model; the first cycle clears both sides.
    for (int n = 0; n < 400; n++) begin
      rclr = (n == 0) || ($urandom_range(31) == 0);
      radd = $urandom_range(1) == 1;
      case ($urandom_range(3))
        0:       rdata = 32'd0;
        1:       rdata = 32'hFFFF_FFFF;
        default: rdata = $urandom;
      endcase
      modelStep(rclr, radd, rdata);
      step(rclr, radd, rdata);
      check("rnd_main_ready", 64'(mainReady), 64'(mReady));
      check("rnd_main_out",   64'(mainOut),   64'(mOut));
      check("rnd_main_full",  64'(mainFull),  64'(q32.size() == 8));
      check("rnd_round_ready", 64'(rndReady), 64'(mReady));
      check("rnd_round_out",   64'(rndOut),   64'(mRnd));
      check("rnd_sml_ready", 64'(smlReady), 64'(sReady));
      check("rnd_sml_out",   64'(smlOut),   64'(sOut));
      check("rnd_sml_full",  64'(smlFull),  64'(q8.size() == 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/window_average.md
WINDOW_AVERAGE -- requirements
Module: window_average

Interface
REQ-001 Parameter DATA_W, default 32: sample and result width in bits, range 8..32.
REQ-002 Parameter DEPTH_LOG2, default 3: the window holds 2**DEPTH_LOG2 samples, range 1..6.
REQ-003 Parameter ROUND, default 0: 0 truncates the quotient; 1 rounds half-up by adding 2**(DEPTH_LOG2-1) before the shift.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 n_rst  input  1  reset, asynchronous and active-low.
REQ-006 clear  input  1  synchronous flush of the window.
REQ-007 addValue  input  1  sample strobe; one sample accepted per high cycle.
REQ-008 inputData  input  DATA_W  unsigned sample, qualified by addValue.
REQ-009 averageReady  output  1  one-cycle pulse, result valid.
REQ-010 outputData  output  DATA_W  unsigned windowed mean, held between pulses.
REQ-011 windowFull  output  1  level, high once 2**DEPTH_LOG2 samples are held.

Function
REQ-012 Storage is a circular buffer of 2**DEPTH_LOG2 entries with a DEPTH_LOG2-bit write pointer that wraps from max to 0.
REQ-013 The running sum is DATA_W+DEPTH_LOG2 bits wide (DATA_W+DEPTH_LOG2+1 when ROUND=1) and never overflows.
REQ-014 The fill count saturates at 2**DEPTH_LOG2; windowFull = (count == 2**DEPTH_LOG2).
REQ-015 On an edge with addValue=1 and clear=0: write inputData at the pointer, increment the pointer, and set sum <= sum + inputData - oldest, where oldest = buffer[pointer] if the window is full, else 0.
REQ-016 On the same edge, when the post-update count equals 2**DEPTH_LOG2: outputData <= (new sum [+ round term]) >> DEPTH_LOG2, and averageReady <= 1.
REQ-017 Latency: a sample strobed at edge k produces averageReady high for exactly the cycle after edge k.
REQ-018 The strobe that fills the window produces the first averageReady pulse.
REQ-019 Before the window is full, averageReady stays 0 and outputData keeps its previous value.
REQ-020 On edges without addValue: averageReady <= 0 and all other state holds.
REQ-021 Back-to-back addValue on consecutive cycles is legal; each strobe yields one pulse once the window is full.
REQ-022 clear=1 takes priority over addValue: count, sum, pointer, outputData and averageReady go to 0 at that edge, and the sample is discarded.
REQ-023 Buffer contents are not cleared by clear or reset; the count gating in REQ-015 makes stale entries unobservable.
REQ-024 The rounded result cannot exceed 2**DATA_W-1; no saturation logic is required.

Reset
REQ-025 n_rst=0 immediately forces averageReady=0, outputData=0, windowFull=0, count=0, sum=0, pointer=0, independent of clk.
REQ-026 Reset asserted mid-window discards the partial window; after release, 2**DEPTH_LOG2 new samples are needed before the next pulse.
REQ-027 The first edge after n_rst deasserts behaves as a normal cycle.

Verification (DATA_W=32, DEPTH_LOG2=3)
REQ-028 Fill and steady state:
- Stimulus: seven strobes of 1.
- Required: no averageReady, windowFull=0.
- Eighth strobe of 1: pulse one cycle later, outputData=1, windowFull=1.
REQ-029 Sliding window:
- Stimulus: after REQ-028, strobes of 54321, spaced 10 idle cycles apart.
- Required: first pulse outputData=6791 (54328>>3); eighth pulse outputData=54321; exactly one pulse per strobe.
REQ-030 Overflow and back-to-back:
- Stimulus: eight consecutive-cycle strobes of 0xFFFFFFFF.
- Required: a single pulse on the cycle after the eighth strobe, outputData=0xFFFFFFFF; then 0 x8 ends with outputData=0.
REQ-031 Rounding:
- Stimulus: samples 4,0,0,0,0,0,0,0.
- Required: ROUND=0 gives outputData=0; ROUND=1 gives outputData=1.
REQ-032 Clear and reset:
- Stimulus 1: clear and addValue asserted together after 5 strobes.
- Required 1: no pulse; eight more strobes are needed.
- Stimulus 2: n_rst pulsed low between clock edges mid-window.
- Required 2: outputs go to 0 before the next edge.
REQ-033 Parameter sweep: repeat REQ-028 with DEPTH_LOG2=1 and DATA_W=8; the first pulse comes on the second strobe.
